// File: rtl/qerv_dbus_resp.sv
// Wishbone-classic data-bus responder backed by a word-organised local RAM.
// Acks every transfer with a single-cycle strobe after a programmable number of wait states.
module qerv_dbus_resp #(
    parameter int  DEPTH       = 256,
    parameter int  WAIT_STATES = 0,
    localparam int AW          = $clog2(DEPTH)
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_wb_adr,
    input  logic [31:0] i_wb_dat,
    input  logic [3:0]  i_wb_sel,
    input  logic        i_wb_we,
    input  logic        i_wb_cyc,
    output logic [31:0] o_wb_rdt,
    output logic        o_wb_ack
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    localparam logic [3:0] WS = WAIT_STATES[3:0];

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_nxt;
    logic        r_ack;
    logic [31:0] r_rdt;
    logic [31:0] r_mem [DEPTH];

    logic [AW-1:0] w_idx;
    logic          w_enter_ack;
    logic          w_mem_we;
    logic          w_mem_rd;
    logic          w_unused_adr;

    // Replace only the byte lanes whose select bit is set.
    function automatic logic [31:0] f_merge(input logic [31:0] old_word,
                                            input logic [31:0] new_word,
                                            input logic [3:0]  sel);
        logic [31:0] res;
        res = old_word;
        for (int n = 0; n < 4; n++) begin
            if (sel[n]) begin
                res[8*n +: 8] = new_word[8*n +: 8];
            end else begin
                res[8*n +: 8] = old_word[8*n +: 8];
            end
        end
        return res;
    endfunction

    assign w_idx        = i_wb_adr[AW+1:2];
    assign w_unused_adr = ^{i_wb_adr[31:AW+2], i_wb_adr[1:0]};

    // State, wait counter and registered bus outputs.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_ack   <= 1'b0;
            r_rdt   <= 32'h0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ack   <= w_enter_ack;
            if (w_mem_rd) begin
                r_rdt <= r_mem[w_idx];
            end else begin
                r_rdt <= r_rdt;
            end
        end
    end

    // Next-state logic; a dropped cyc in WAIT aborts even when the count has reached 1.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (i_wb_cyc) begin
                    w_cnt_nxt = WS;
                    if (WS == 4'd0) begin
                        w_state_nxt = S_ACK;
                    end else begin
                        w_state_nxt = S_WAIT;
                    end
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_WAIT: begin
                if (!i_wb_cyc) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = 4'd0;
                end else if (r_cnt == 4'd1) begin
                    w_state_nxt = S_ACK;
                    w_cnt_nxt   = 4'd0;
                end else begin
                    w_state_nxt = S_WAIT;
                    w_cnt_nxt   = r_cnt - 4'd1;
                end
            end
            S_ACK: begin
                w_state_nxt = S_HOLD;
            end
            S_HOLD: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    // Transfer strobes: the bus is sampled only on the edge that enters ACK.
    always_comb begin
        w_enter_ack = 1'b0;
        w_mem_we    = 1'b0;
        w_mem_rd    = 1'b0;
        if ((w_state_nxt == S_ACK) && (r_state != S_ACK)) begin
            w_enter_ack = 1'b1;
            w_mem_we    = i_wb_we;
            w_mem_rd    = ~i_wb_we;
        end else begin
            w_enter_ack = 1'b0;
            w_mem_we    = 1'b0;
            w_mem_rd    = 1'b0;
        end
    end

    // RAM write port; contents are deliberately not reset, and reset blocks the commit.
    always_ff @(posedge i_clk) begin
        if (i_rst_n && w_mem_we) begin
            r_mem[w_idx] <= f_merge(r_mem[w_idx], i_wb_dat, i_wb_sel);
        end
    end

    assign o_wb_ack = r_ack;
    assign o_wb_rdt = r_rdt;

endmodule

// File: tb/tb_qerv_dbus_resp.sv
// Directed bench for qerv_dbus_resp: one instance with no wait states, one with three.
module tb_qerv_dbus_resp;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] adr, dat;
    logic [3:0]  sel;
    logic        we;
    logic        cyc0, cyc3;
    logic [31:0] rdt0, rdt3;
    logic        ack0, ack3;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    qerv_dbus_resp #(.DEPTH(256), .WAIT_STATES(0)) u_dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_wb_adr(adr), .i_wb_dat(dat),
        .i_wb_sel(sel), .i_wb_we(we), .i_wb_cyc(cyc0),
        .o_wb_rdt(rdt0), .o_wb_ack(ack0)
    );

    qerv_dbus_resp #(.DEPTH(256), .WAIT_STATES(3)) u_dut3 (
        .i_clk(clk), .i_rst_n(rst_n), .i_wb_adr(adr), .i_wb_dat(dat),
        .i_wb_sel(sel), .i_wb_we(we), .i_wb_cyc(cyc3),
        .o_wb_rdt(rdt3), .o_wb_ack(ack3)
    );

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic [31:0] exp_rdt;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One complete transfer; lat counts clock edges from the request edge to the ack cycle.
    task automatic txn(input int d, input logic t_we, input logic [31:0] t_adr,
                       input logic [31:0] t_dat, input logic [3:0] t_sel,
                       output int lat, output logic [31:0] rdt);
        bit got;
        got = 1'b0;
        lat = -1;
        @(posedge clk); #1;
        we = t_we; adr = t_adr; dat = t_dat; sel = t_sel;
        if (d == 0) cyc0 = 1'b1; else cyc3 = 1'b1;
        for (int i = 1; i <= 30 && !got; i++) begin
            @(posedge clk);
            @(negedge clk);
            if ((d == 0) ? ack0 : ack3) begin
                got = 1'b1;
                lat = i;
            end
        end
        rdt = (d == 0) ? rdt0 : rdt3;
        @(posedge clk); #1;
        cyc0 = 1'b0;
        cyc3 = 1'b0;
        @(negedge clk);
        chk("ack_one_cycle", {31'd0, ((d == 0) ? ack0 : ack3)}, 32'd0);
    endtask

    // Start a write on the 3-wait instance, drop cyc after hold edges, expect no ack.
    task automatic abort_write(input int hold);
        bit seen;
        seen = 1'b0;
        @(posedge clk); #1;
        we = 1'b1; adr = 32'h30; dat = 32'hFFFF_FFFF; sel = 4'hF; cyc3 = 1'b1;
        repeat (hold) @(posedge clk);
        #1 cyc3 = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (ack3) seen = 1'b1;
        end
        chk("abort_no_ack", {31'd0, seen}, 32'd0);
    endtask

    initial begin
        int          lat;
        int          gap;
        bit          got;
        logic [31:0] r;

        vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0000_0000};
        vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0000_0000, 4'hF, 32'hDEAD_BEEF};
        vecs[2]  = '{1'b1, 32'h0000_0020, 32'h1122_3344, 4'hF, 32'hDEAD_BEEF};
        vecs[3]  = '{1'b1, 32'h0000_0020, 32'hAABB_CCDD, 4'h5, 32'hDEAD_BEEF};
        vecs[4]  = '{1'b0, 32'h0000_0020, 32'h0000_0000, 4'h0, 32'h11BB_33DD};
        vecs[5]  = '{1'b1, 32'h0000_0020, 32'hFFFF_FFFF, 4'h0, 32'h11BB_33DD};
        vecs[6]  = '{1'b0, 32'h0000_0020, 32'h0000_0000, 4'h1, 32'h11BB_33DD};
        vecs[7]  = '{1'b1, 32'h0000_0400, 32'hCAFE_F00D, 4'hF, 32'h11BB_33DD};
        vecs[8]  = '{1'b0, 32'h0000_0000, 32'h0000_0000, 4'hF, 32'hCAFE_F00D};
        vecs[9]  = '{1'b1, 32'h0000_03FC, 32'hA5A5_A5A5, 4'hF, 32'hCAFE_F00D};
        vecs[10] = '{1'b1, 32'h0000_03FC, 32'h5A00_0000, 4'h8, 32'hCAFE_F00D};
        vecs[11] = '{1'b0, 32'hFFFF_F3FC, 32'h0000_0000, 4'hF, 32'h5AA5_A5A5};
        vecs[12] = '{1'b1, 32'h0000_0013, 32'h1234_5678, 4'h3, 32'h5AA5_A5A5};
        vecs[13] = '{1'b0, 32'h0000_0010, 32'h0000_0000, 4'hF, 32'hDEAD_5678};
        vecs[14] = '{1'b0, 32'h0000_0003, 32'h0000_0000, 4'hF, 32'hCAFE_F00D};

        rst_n = 1'b0; cyc0 = 1'b0; cyc3 = 1'b0; we = 1'b0;
        adr = 32'h0; dat = 32'h0; sel = 4'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_ack0", {31'd0, ack0}, 32'd0);
        chk("reset_rdt0", rdt0, 32'h0);
        chk("reset_ack3", {31'd0, ack3}, 32'd0);
        chk("reset_rdt3", rdt3, 32'h0);
        @(posedge clk); #1 rst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            txn(0, vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].sel, lat, r);
            chk($sformatf("ws0_lat[%0d]", i), lat, 32'd1);
            chk($sformatf("ws0_rdt[%0d]", i), r, vecs[i].exp_rdt);
        end

        // A write whose ACK-entry edge coincides with reset must not land.
        @(posedge clk); #1;
        we = 1'b1; adr = 32'h10; dat = 32'h0; sel = 4'hF; cyc0 = 1'b1; rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1; cyc0 = 1'b0;
        chk("rst_write_ack", {31'd0, ack0}, 32'd0);
        chk("rst_write_rdt", rdt0, 32'h0);
        txn(0, 1'b0, 32'h10, 32'h0, 4'hF, lat, r);
        chk("rst_write_keep", r, 32'hDEAD_5678);

        txn(3, 1'b1, 32'h30, 32'h1234_5678, 4'hF, lat, r);
        chk("ws3_wr_lat", lat, 32'd4);
        txn(3, 1'b0, 32'h30, 32'h0, 4'hF, lat, r);
        chk("ws3_rd_lat", lat, 32'd4);
        chk("ws3_rd_rdt", r, 32'h1234_5678);

        // cyc held across the ack: the second ack follows HOLD, IDLE and three waits.
        @(posedge clk); #1;
        we = 1'b0; adr = 32'h30; cyc3 = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (ack3) got = 1'b1;
        end
        chk("b2b_first_ack", {31'd0, got}, 32'd1);
        got = 1'b0;
        gap = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            gap++;
            if (ack3) got = 1'b1;
        end
        chk("b2b_gap", gap, 32'd6);
        @(posedge clk); #1 cyc3 = 1'b0;
        @(negedge clk);
        chk("b2b_ack_single", {31'd0, ack3}, 32'd0);
        repeat (2) @(posedge clk);

        abort_write(2);
        txn(3, 1'b0, 32'h30, 32'h0, 4'hF, lat, r);
        chk("abort2_rdt", r, 32'h1234_5678);
        abort_write(3);
        txn(3, 1'b0, 32'h30, 32'h0, 4'hF, lat, r);
        chk("abort3_rdt", r, 32'h1234_5678);

        // Reset pulse while the 3-wait instance is counting.
        @(posedge clk); #1;
        we = 1'b0; adr = 32'h30; cyc3 = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1; cyc3 = 1'b0;
        chk("midwait_rst_ack", {31'd0, ack3}, 32'd0);
        chk("midwait_rst_rdt", rdt3, 32'h0);
        txn(3, 1'b0, 32'h30, 32'h0, 4'hF, lat, r);
        chk("post_rst_lat", lat, 32'd4);
        chk("post_rst_rdt", r, 32'h1234_5678);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/qerv_dbus_resp.md
# qerv_dbus_resp

Wishbone-classic data-bus responder with local word-organised RAM. It sits at the far end of the core's data bus and serves the store data and byte selects driven by the core's buffer register. It returns load data with a single-cycle ack that the core's buffer register latches. Wait-state latency is programmable so bench and SoC can exercise the core's stall paths.

## Interface
- DEPTH, 256, number of 32-bit words; power of two, >= 4
- WAIT_STATES, 0, extra idle cycles inserted before ack; 0..15
- AW, $clog2(DEPTH), word-index width; derived, not overridden
- i_clk  in  1  clock, all state on rising edge
- i_rst_n  in  1  reset, synchronous, active-low
- i_wb_adr  in  32  byte address; bits [AW+1:2] index the word, all other bits ignored
- i_wb_dat  in  32  write data
- i_wb_sel  in  4  byte-lane enables; bit n covers dat[8n+7:8n]
- i_wb_we  in  1  1 = write, 0 = read
- i_wb_cyc  in  1  request valid; held by initiator until ack
- o_wb_rdt  out  32  read data, valid in ack cycle
- o_wb_ack  out  1  single-cycle completion strobe

## Operation
- States: IDLE, WAIT, ACK, HOLD.
- IDLE: if i_wb_cyc=1, then load wait counter with WAIT_STATES.
  - Go to ACK if WAIT_STATES=0, else WAIT.
- WAIT: counter decrements by 1 each cycle.
  - When the counter is 1, the next state is ACK.
  - If i_wb_cyc drops, go to IDLE: request aborted, no write, no ack.
- ACK: o_wb_ack=1 for exactly this one cycle.
  - Next state is HOLD unconditionally.
- HOLD: ignores i_wb_cyc for one cycle, then goes to IDLE.
  - HOLD exists because the initiator deasserts cyc registered off ack.
  - Back-to-back requests therefore start no earlier than 2 cycles after ack.
- Write: committed on the clock edge that enters ACK.
  - Each byte lane with i_wb_sel[n]=1 is updated. Other lanes are unchanged.
  - sel=4'b0000 is acked with no memory change.
- Read: o_wb_rdt is loaded with mem[index] on the edge entering ACK.
  - All four lanes are returned regardless of sel; lane selection is the initiator's job.
  - o_wb_rdt holds its value until the next read completes. Writes do not alter o_wb_rdt.
- Address, data, sel and we are sampled on the edge entering ACK, not at request start.
- The initiator must hold them stable while cyc=1.
- Index wraps modulo DEPTH. No bus error exists.

## Timing
- Reset values: o_wb_ack=0, o_wb_rdt=32'h0, state IDLE, wait counter 0.
- RAM contents are not reset.
- Latency: cyc sampled high in IDLE at edge k means ack is high in cycle k+1+WAIT_STATES.
- Reset asserted in any state: the next state is IDLE and ack=0.
  - A write whose ACK-entry edge coincides with reset is not committed.
- Reset dominates all other inputs.
- cyc deasserted during ACK or HOLD has no effect. The transfer is already complete.
- cyc deasserted on the same edge the counter reaches 1 counts as an abort. No ACK occurs.
- o_wb_ack never asserts in two consecutive cycles.
- o_wb_ack never asserts while i_wb_cyc was low on the preceding edge.

## Test plan
- WAIT_STATES=0: write 32'hDEADBEEF, sel=4'hF, adr=0x10, then read 0x10.
  - Each ack comes 1 cycle after cyc.
  - rdt=32'hDEADBEEF in the read ack cycle.
- Byte lanes: preload adr 0x20 with 32'h11223344.
  - Write 32'hAABBCCDD with sel=4'b0101.
  - Read back 32'h11BB33DD.
  - sel=0 write leaves the value unchanged and is still acked.
- WAIT_STATES=3: read issued at edge k gives ack in cycle k+4, high for exactly 1 cycle.
  - Next request issued immediately after ack is not acked before cycle ack+2+4.
- Abort: WAIT_STATES=3, write to 0x30, cyc dropped after 2 cycles.
  - No ack occurs.
  - Subsequent read of 0x30 returns the prior contents.
- Reset mid-WAIT: i_rst_n=0 for 1 cycle during WAIT.
  - ack=0, rdt=0, state IDLE.
  - New read then completes with normal latency.
- Wrap: DEPTH=256, write 32'hCAFEF00D to adr 0x400.
  - Read adr 0x000 returns 32'hCAFEF00D.
